// File: rtl/template_ram_writer.sv
// Captures one frame of a pixel stream into a single-port template RAM, packing
// pixels LSB-first into words written sequentially from address 0.
module template_ram_writer #(
  parameter int c_ADDR_WIDTH = 10,
  parameter int c_DATA_WIDTH = 32,
  parameter int c_PIX_WIDTH  = 8,
  parameter int c_NUM_WORDS  = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [c_PIX_WIDTH-1:0]                pix_data,
  input  logic                                  pix_valid,
  input  logic                                  pix_sof,
  input  logic                                  pix_eof,
  output logic                                  pix_ready,
  output logic [c_ADDR_WIDTH-1:0]               ram_addr,
  output logic [c_DATA_WIDTH-1:0]               ram_wr_data,
  output logic                                  ram_wr_en,
  output logic [c_DATA_WIDTH/c_PIX_WIDTH-1:0]   ram_wr_byte_en,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  short_frame
);

  localparam int LANES  = c_DATA_WIDTH / c_PIX_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_ADDR_WIDTH-1:0] LAST_WORD = c_ADDR_WIDTH'(c_NUM_WORDS - 1);
  localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(LANES - 1);

  // Pixel handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both high; pix_ready is registered and only high while
  // waiting for sof or filling, so it never depends on the current inputs.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    FILL     = 3'd2,
    FLUSH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                  state;
  logic [LANE_W-1:0]       lane_cnt;
  logic [c_DATA_WIDTH-1:0] word_buf;
  logic [c_ADDR_WIDTH-1:0] word_cnt;
  logic                    full_hit;

  logic [LANE_W-1:0]       base_lane;
  logic [c_DATA_WIDTH-1:0] base_buf;
  logic [c_ADDR_WIDTH-1:0] base_wc;
  logic [c_DATA_WIDTH-1:0] fill_buf;
  logic [LANES-1:0]        fill_mask;
  logic                    last_lane;
  logic                    last_word;
  logic                    take;

  // An sof pixel restarts the word from lane 0 at address 0, dropping partial lanes.
  always_comb begin
    base_lane = pix_sof ? '0 : lane_cnt;
    base_buf  = pix_sof ? '0 : word_buf;
    base_wc   = pix_sof ? '0 : word_cnt;
    fill_buf  = base_buf;
    fill_buf[int'(base_lane)*c_PIX_WIDTH +: c_PIX_WIDTH] = pix_data;
    for (int k = 0; k < LANES; k++) begin
      fill_mask[k] = (k <= int'(base_lane));
    end
    last_lane = (base_lane == LAST_LANE);
    last_word = (base_wc == LAST_WORD);
    take      = pix_valid && pix_ready && ((state == FILL) || pix_sof);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lane_cnt       <= '0;
      word_buf       <= '0;
      word_cnt       <= '0;
      full_hit       <= 1'b0;
      pix_ready      <= 1'b0;
      ram_addr       <= '0;
      ram_wr_data    <= '0;
      ram_wr_en      <= 1'b0;
      ram_wr_byte_en <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      short_frame    <= 1'b0;
    end else begin
      ram_wr_en      <= 1'b0;
      ram_wr_byte_en <= '0;
      done           <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        pix_ready <= 1'b0;
        busy      <= 1'b0;
        lane_cnt  <= '0;
        word_buf  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= WAIT_SOF;
              pix_ready   <= 1'b1;
              busy        <= 1'b1;
              short_frame <= 1'b0;
              ram_addr    <= '0;
              word_cnt    <= '0;
              lane_cnt    <= '0;
              word_buf    <= '0;
            end
          end
          WAIT_SOF, FILL: begin
            if (take) begin
              if (last_lane || pix_eof) begin
                // Word complete or frame ended: present the write next cycle.
                ram_wr_en      <= 1'b1;
                ram_wr_data    <= fill_buf;
                ram_wr_byte_en <= fill_mask;
                ram_addr       <= base_wc;
                word_cnt       <= base_wc + 1'b1;
                lane_cnt       <= '0;
                word_buf       <= '0;
                if (last_lane && last_word) begin
                  state     <= FLUSH;
                  pix_ready <= 1'b0;
                  full_hit  <= 1'b1;
                end else if (pix_eof) begin
                  state     <= FLUSH;
                  pix_ready <= 1'b0;
                  full_hit  <= 1'b0;
                end else begin
                  state <= FILL;
                end
              end else begin
                lane_cnt <= base_lane + 1'b1;
                word_buf <= fill_buf;
                word_cnt <= base_wc;
                state    <= FILL;
                if (pix_sof) begin
                  ram_addr <= '0;
                end
              end
            end
          end
          FLUSH: begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            short_frame <= !full_hit;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_template_ram_writer.sv
// Bench for template_ram_writer: random pixel frames against a frame-level model
// whose expected RAM writes and done pulses are checked by a separate monitor.
module tb_template_ram_writer;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int PW    = 8;
  localparam int NW    = 4;
  localparam int LANES = DW / PW;
  localparam int WW    = 16 + AW + LANES + DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PW-1:0]    pix_data = '0;
  logic             pix_valid = 1'b0;
  logic             pix_sof = 1'b0;
  logic             pix_eof = 1'b0;
  logic             pix_ready;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wr_data;
  logic             ram_wr_en;
  logic [LANES-1:0] ram_wr_byte_en;
  logic             busy;
  logic             done;
  logic             short_frame;

  template_ram_writer #(
    .c_ADDR_WIDTH(AW), .c_DATA_WIDTH(DW), .c_PIX_WIDTH(PW), .c_NUM_WORDS(NW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .pix_ready(pix_ready), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_en(ram_wr_en), .ram_wr_byte_en(ram_wr_byte_en),
    .busy(busy), .done(done), .short_frame(short_frame)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {cycle, addr, byte_en, data} and {cycle, short_frame}
  logic [WW-1:0] exp_q[$];
  logic [16:0]   done_q[$];
  int errors = 0;
  int checks = 0;

  // frame-level reference model
  logic          m_cap = 1'b0;
  logic          m_wait_sof = 1'b0;
  logic [PW-1:0] cur[$];
  int            widx = 0;
  int            flush_cyc = -10;
  int            idle_from = 0;
  logic          sf_old = 1'b0;
  logic          sf_new = 1'b0;
  int            sf_cyc = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic exp_sf(int c);
    return (c >= sf_cyc) ? sf_new : sf_old;
  endfunction

  function automatic void push_wr(int c);
    logic [DW-1:0]    data;
    logic [LANES-1:0] be;
    data = '0;
    be   = '0;
    foreach (cur[i]) begin
      data = data | (DW'(cur[i]) << (PW * i));
      be[i] = 1'b1;
    end
    exp_q.push_back({16'(c), AW'(widx), be, data});
  endfunction

  function automatic void finish_frame(logic sh, int k);
    done_q.push_back({16'(k + 2), sh});
    m_cap     = 1'b0;
    flush_cyc = k + 1;
    idle_from = k + 3;
    sf_old    = exp_sf(k);
    sf_new    = sh;
    sf_cyc    = k + 2;
  endfunction

  function automatic void purge(int k);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (int'(exp_q[i][WW-1 -: 16]) > k) exp_q.delete(i);
    for (int i = done_q.size() - 1; i >= 0; i--)
      if (int'(done_q[i][16:1]) > k) done_q.delete(i);
  endfunction

  function automatic void accept(logic [PW-1:0] d, logic s, logic e, int k);
    if (m_wait_sof && !s) return;
    if (s) begin
      cur.delete();
      widx = 0;
      m_wait_sof = 1'b0;
    end
    cur.push_back(d);
    if (cur.size() == LANES) begin
      push_wr(k + 1);
      widx++;
      cur.delete();
      if (widx == NW) finish_frame(1'b0, k);
      else if (e) finish_frame(1'b1, k);
    end else if (e) begin
      push_wr(k + 1);
      finish_frame(1'b1, k);
    end
  endfunction

  // driver: called at a falling edge, drives one cycle of inputs
  task automatic step(input logic v, input logic [PW-1:0] d, input logic s,
                      input logic e, input logic st, input logic ab);
    int k;
    rst = 1'b0; pix_valid = v; pix_data = d; pix_sof = s; pix_eof = e;
    start = st; abort = ab;
    k = cyc;
    check("pix_ready", 64'(pix_ready), 64'(m_cap));
    check("busy", 64'(busy), 64'(m_cap || (k == flush_cyc)));
    check("short_frame", 64'(short_frame), 64'(exp_sf(k)));
    if (ab) begin
      if (m_cap) begin
        purge(k);
        m_cap = 1'b0;
        cur.delete();
        idle_from = k + 1;
      end
    end else if (st && !m_cap && (k >= idle_from)) begin
      m_cap = 1'b1;
      m_wait_sof = 1'b1;
      sf_old = exp_sf(k);
      sf_new = 1'b0;
      sf_cyc = k + 1;
    end else if (v && m_cap) begin
      accept(d, s, e, k);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [PW-1:0] d, input logic s, input logic e, input int gap);
    idle($urandom_range(0, gap));
    step(1'b1, d, s, e, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    int t = 0;
    while (cyc < idle_from && t < 20) begin
      idle(1);
      t++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    int k;
    k = cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
    purge(k);
    m_cap = 1'b0; cur.delete();
    flush_cyc = -10; idle_from = k + 1;
    sf_old = 1'b0; sf_new = 1'b0; sf_cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_wr_en", 64'(ram_wr_en), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wr_data", 64'(ram_wr_data), 64'd0);
    check("rst_byte_en", 64'(ram_wr_byte_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_short_frame", 64'(short_frame), 64'd0);
  endtask

  // monitor: pops expectations whenever the DUT writes or signals done
  always @(negedge clk) begin
    logic [WW-1:0] e;
    logic [16:0]   dn;
    while (exp_q.size() > 0 && int'(exp_q[0][WW-1 -: 16]) < cyc) begin
      e = exp_q.pop_front();
      check("missed_write", 64'(0), 64'(e[WW-1 -: 16]));
    end
    while (done_q.size() > 0 && int'(done_q[0][16:1]) < cyc) begin
      dn = done_q.pop_front();
      check("missed_done", 64'(0), 64'(dn[16:1]));
    end
    if (ram_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(ram_addr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e[WW-1 -: 16]));
        check("wr_addr", 64'(ram_addr), 64'(e[DW+LANES +: AW]));
        check("wr_byte_en", 64'(ram_wr_byte_en), 64'(e[DW +: LANES]));
        check("wr_data", 64'(ram_wr_data), 64'(e[DW-1:0]));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("extra_done", 64'(1), 64'(0));
      end else begin
        dn = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(dn[16:1]));
        check("done_short_frame", 64'(short_frame), 64'(dn[0]));
        check("done_busy", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset();

    // full template, continuous valid
    do_start();
    for (int i = 0; i < 16; i++) send(PW'(i), i == 0, 1'b0, 0);
    idle(4);

    // early eof on the sixth pixel
    do_start();
    for (int i = 0; i < 6; i++) send(PW'(i), i == 0, i == 5, 0);
    idle(4);

    // junk before sof, random valid gaps
    do_start();
    repeat (5) send(PW'($urandom_range(0, 255)), 1'b0, 1'b0, 2);
    for (int i = 0; i < 16; i++) send(PW'(i), i == 0, 1'b0, 3);
    idle(4);

    // sof re-asserted mid-frame, then pixels after done are refused
    do_start();
    for (int i = 0; i < 9; i++) send(PW'(8'h40 + i), i == 0, 1'b0, 0);
    for (int i = 0; i < 16; i++) send(PW'(8'h80 + i), i == 0, 1'b0, 0);
    repeat (3) send(8'hEE, 1'b0, 1'b0, 0);
    idle(4);

    // abort with two pending lanes, then a fresh capture
    do_start();
    for (int i = 0; i < 6; i++) send(PW'(8'h10 + i), i == 0, 1'b0, 0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    do_start();
    for (int i = 0; i < 16; i++) send(PW'($urandom_range(0, 255)), i == 0, 1'b0, 1);
    idle(4);

    // start while busy, reset mid-fill, eof on the final pixel of a full template
    do_start();
    for (int i = 0; i < 5; i++) send(PW'(8'h20 + i), i == 0, 1'b0, 0);
    step(1'b1, 8'h25, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h26, 1'b0, 1'b0, 0);
    do_reset();
    idle(2);
    do_start();
    for (int i = 0; i < 16; i++) send(PW'(8'hA0 + i), i == 0, i == 15, 0);
    idle(4);

    // random frames
    repeat (30) begin
      do_start();
      repeat ($urandom_range(0, 2)) send(PW'($urandom_range(0, 255)), 1'b0, 1'b0, 1);
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) begin
        send(PW'($urandom_range(0, 255)), (i == 0) || ($urandom_range(0, 15) == 0),
             (i == n - 1) && ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1) ? 0 : 2);
        if (!m_cap) break;
      end
      if (m_cap) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(4);
    end

    idle(3);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("pending_dones", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
